// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture
// (write-1-to-clear) and a maskable level interrupt.
module pio_in_edge_capture #(
    parameter int         WIDTH       = 32,
    parameter int         SYNC_STAGES = 2,
    parameter logic [1:0] RESET_MODE  = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int CW      = $clog2(ARM_MAX + 1);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [1:0]       mode_q;
    logic [CW-1:0]    arm_cnt;

    logic             armed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic             wr_mode;
    logic             wr_mask;
    logic [31:0]      rd_next;

    assign sync_q   = sync_r[SYNC_STAGES-1];
    assign armed    = (arm_cnt == CW'(ARM_MAX));
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;
    assign edge_hit = (mode_q[0] ? rise : '0)
                    | (mode_q[1] ? fall : '0);
    assign wr_mode  = write && (address == 2'd1);
    assign wr_mask  = write && (address == 2'd2);
    assign clr      = (write && (address == 2'd3))
                    ? writedata[WIDTH-1:0] : '0;

    // Built only from registered state, so the request never glitches.
    assign irq = |(cap_q & mask_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_r[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_r[i] <= sync_r[i-1];
            prev_q <= sync_q;
        end
    end

    // Hold off capture until the synchroniser and prev_q hold real data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            arm_cnt <= '0;
        else if (!armed)
            arm_cnt <= arm_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= RESET_MODE;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            if (wr_mode)
                mode_q <= writedata[1:0];
            if (wr_mask)
                mask_q <= writedata[WIDTH-1:0];
            cap_q <= (cap_q & ~clr) | (armed ? edge_hit : '0);
        end
    end

    always_comb begin
        rd_next = '0;
        unique case (address)
            2'd0: rd_next[WIDTH-1:0] = sync_q;
            2'd1: rd_next[1:0]       = mode_q;
            2'd2: rd_next[WIDTH-1:0] = mask_q;
            2'd3: rd_next[WIDTH-1:0] = cap_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Directed bench for pio_in_edge_capture: default build plus
// a WIDTH=8, SYNC_STAGES=3 build.
module tb_pio_in_edge_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    logic        rst2;
    logic [1:0]  addr2;
    logic        wr2_s;
    logic [31:0] wd2;
    logic [7:0]  in2;
    logic [31:0] rdata2;
    logic        irq2;

    int checks = 0;
    int errors = 0;
    logic [31:0] v;

    always #5 clk = ~clk;

    pio_in_edge_capture dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    pio_in_edge_capture #(
        .WIDTH       (8),
        .SYNC_STAGES (3)
    ) dut8 (
        .clk       (clk),
        .reset     (rst2),
        .address   (addr2),
        .write     (wr2_s),
        .writedata (wd2),
        .in_port   (in2),
        .readdata  (rdata2),
        .irq       (irq2)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        write   = 1'b0;
        tick();
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
    endtask

    task automatic rd2(input logic [1:0] a, output logic [31:0] d);
        addr2 = a;
        wr2_s = 1'b0;
        tick();
        d = rdata2;
    endtask

    task automatic wr2(input logic [1:0] a, input logic [31:0] d);
        addr2 = a;
        wd2   = d;
        wr2_s = 1'b1;
        tick();
        wr2_s = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rst2 = 1'b1;
        address = '0; write = 1'b0; writedata = '0;
        addr2 = '0; wr2_s = 1'b0; wd2 = '0;
        in_port = 32'hFFFF_FFFF;
        in2 = 8'hA5;
        tick(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0; rst2 = 1'b0;
        tick(10);

        // reset / arm window
        rd(2'd0, v); chk("arm_data", v, 32'hFFFF_FFFF);
        rd(2'd3, v); chk("arm_edgecap", v, 32'h0);
        chk("arm_irq", {31'b0, irq}, 32'h0);
        rd(2'd1, v); chk("mode_reset", v, 32'h1);
        rd(2'd2, v); chk("mask_reset", v, 32'h0);

        // rising capture on bit0 with latency SYNC_STAGES+1
        in_port = 32'h0;
        tick(5);
        wr(2'd2, 32'h1);
        rd(2'd3, v); chk("fall_ignored", v, 32'h0);
        in_port = 32'h1;
        tick(2);
        chk("rise_irq_early", {31'b0, irq}, 32'h0);
        tick();
        chk("rise_irq_on", {31'b0, irq}, 32'h1);
        rd(2'd3, v); chk("rise_cap", v, 32'h1);
        wr(2'd3, 32'h1);
        chk("w1c_irq_off", {31'b0, irq}, 32'h0);
        rd(2'd3, v); chk("w1c_cap", v, 32'h0);

        // falling mode: bit4 1->0->1 captures once
        wr(2'd1, 32'h0);
        in_port = 32'h11;
        tick(5);
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFE);
        rd(2'd1, v); chk("mode_rb", v, 32'h2);
        in_port = 32'h01;
        tick(5);
        in_port = 32'h11;
        tick(5);
        rd(2'd3, v); chk("fall_cap", v, 32'h10);

        // both edges
        wr(2'd3, 32'h10);
        rd(2'd3, v); chk("both_clr0", v, 32'h0);
        wr(2'd1, 32'h3);
        in_port = 32'h01;
        tick(5);
        rd(2'd3, v); chk("both_fall", v, 32'h10);
        wr(2'd3, 32'h10);
        in_port = 32'h11;
        tick(5);
        rd(2'd3, v); chk("both_rise", v, 32'h10);
        chk("both_irq_masked", {31'b0, irq}, 32'h0);
        wr(2'd3, 32'h10);
        rd(2'd3, v); chk("both_clr", v, 32'h0);

        // masking
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h1);
        in_port = 32'h15;
        tick(5);
        rd(2'd3, v); chk("mask_cap", v, 32'h4);
        chk("mask_irq_off", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h4);
        chk("mask_irq_on", {31'b0, irq}, 32'h1);
        wr(2'd0, 32'h0);
        rd(2'd0, v); chk("data_ro", v, 32'h15);
        wr(2'd3, 32'h4);
        chk("mask_irq_clr", {31'b0, irq}, 32'h0);

        // set wins over clear on the same edge
        in_port = 32'h1D;
        tick(2);
        wr(2'd3, 32'h8);
        rd(2'd3, v); chk("set_wins", v, 32'h8);
        wr(2'd3, 32'h8);
        rd(2'd3, v); chk("set_wins_clr", v, 32'h0);

        // WIDTH=8, SYNC_STAGES=3 build
        rd2(2'd0, v); chk("w8_data", v, 32'h0000_00A5);
        rd2(2'd3, v); chk("w8_arm_cap", v, 32'h0);
        wr2(2'd2, 32'hFFFF_FFFF);
        rd2(2'd2, v); chk("w8_mask", v, 32'h0000_00FF);
        in2 = 8'hA7;
        tick(3);
        chk("w8_irq_early", {31'b0, irq2}, 32'h0);
        tick();
        chk("w8_irq_on", {31'b0, irq2}, 32'h1);
        rd2(2'd3, v); chk("w8_cap", v, 32'h2);
        in2 = 8'hAF;
        tick(2);
        #2 rst2 = 1'b1;
        #1;
        chk("w8_async_rd", rdata2, 32'h0);
        chk("w8_async_irq", {31'b0, irq2}, 32'h0);
        tick(2);
        rst2 = 1'b0;
        tick(10);
        rd2(2'd3, v); chk("w8_rst_cap", v, 32'h0);
        rd2(2'd2, v); chk("w8_rst_mask", v, 32'h0);
        rd2(2'd1, v); chk("w8_rst_mode", v, 32'h1);
        rd2(2'd0, v); chk("w8_rst_data", v, 32'h0000_00AF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
